// File: rtl/uart_program_loader_pkg.sv
// loader_pkg: shared state encodings and protocol constants for the UART program loader
package loader_pkg;
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR} state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with input synchronizer, mid-bit sampling and glitch rejection
module uart_rx
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  logic meta_q, sync_q, prev_q;
  rx_state_t st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic valid_q, valid_d, ferr_q, ferr_d;
  logic tick;
  // Synchronize rx and keep the previous level for start-edge detection; line idles high.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end
  // Receiver state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      st_q    <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end
  // Bit timing: half a bit to the start-bit centre, then a full bit per data/stop sample.
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    tick    = cnt_q == (st_q == RX_START ? HALF : FULL);
    case (st_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync_q) st_d = RX_START;
      end
      RX_START: if (tick) begin
        cnt_d = '0;
        bit_d = '0;
        st_d  = sync_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (tick) begin
        cnt_d = '0;
        sh_d  = {sync_q, sh_q[7:1]};
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) st_d = RX_STOP;
      end
      RX_STOP: if (tick) begin
        st_d    = RX_IDLE;
        valid_d = sync_q;
        ferr_d  = !sync_q;
      end
    endcase
  end
  assign rx_byte    = sh_q;
  assign byte_valid = valid_q;
  assign frame_err  = ferr_q;
endmodule

// File: rtl/uart_program_loader.sv
// uart_program_loader: receives a checksummed program image over UART and writes it into BRAM
module uart_program_loader
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int DEPTH        = 128,
  parameter int ADDR_WIDTH   = 7
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_write_data,
  output logic [3:0]            mem_mask,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  error
);
  logic [7:0] rx_byte;
  logic byte_valid, frame_err;
  state_t state_q, state_d;
  logic [15:0] count_q, count_d, n;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d, addr_q, addr_d;
  logic [1:0] byte_idx_q, byte_idx_d;
  logic [31:0] word_q, word_d, wdata_q, wdata_d;
  logic [7:0] sum_q, sum_d;
  logic we_q, we_d, last;
  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );
  // Frame FSM, word assembly, checksum and registered BRAM write port.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      idx_q      <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      sum_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      sum_q      <= sum_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end
  // Next-state: a framing error aborts any frame except after a verified image.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    idx_d      = idx_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    sum_d      = sum_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    n          = {rx_byte, count_q[7:0]};
    last       = {{(16 - ADDR_WIDTH){1'b0}}, idx_q} == count_q - 16'd1;
    if (frame_err && state_q != DONE) begin
      state_d = ERROR;
    end else if (byte_valid) begin
      case (state_q)
        IDLE, ERROR: if (rx_byte == SYNC_BYTE) state_d = LEN_LO;
        LEN_LO: begin
          count_d = {8'h00, rx_byte};
          state_d = LEN_HI;
        end
        LEN_HI: begin
          count_d    = n;
          idx_d      = '0;
          byte_idx_d = '0;
          sum_d      = '0;
          state_d    = (n == 16'd0 || n > 16'(DEPTH)) ? ERROR : DATA;
        end
        DATA: begin
          word_d[8*byte_idx_q +: 8] = rx_byte;
          sum_d      = sum_q + rx_byte;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = idx_q;
            wdata_d = {rx_byte, word_q[23:0]};
            idx_d   = idx_q + 1'b1;
            if (last) state_d = CHECK;
          end
        end
        CHECK: state_d = (rx_byte == sum_q) ? DONE : ERROR;
        default: ;
      endcase
    end
  end
  assign mem_write_enable = we_q;
  assign mem_addr         = addr_q;
  assign mem_write_data   = wdata_q;
  assign mem_mask         = 4'b1111;
  assign cpu_reset        = state_q != DONE;
  assign busy             = state_q inside {LEN_LO, LEN_HI, DATA, CHECK};
  assign error            = state_q == ERROR;
endmodule
